// File: rtl/fetch_sequencer_if.sv
// Sequencer-to-datapath bundle: program counter handshake, instruction memory
// port and decoded instruction outputs.
interface fetch_sequencer_if;
    logic [15:0]        CounterValue;
    logic [15:0]        MemData;
    logic               MemReady;
    logic               Zero;
    logic               Stall;
    logic [15:0]        MemAddr;
    logic               MemRead;
    logic               LoadEnable;
    logic [15:0]        LoadValue;
    logic               OffsetEnable;
    logic signed [8:0]  Offset;
    logic [15:0]        Instr;
    logic               InstrValid;
    logic               Halted;

    modport master (
        input  CounterValue,
        input  MemData,
        input  MemReady,
        input  Zero,
        input  Stall,
        output MemAddr,
        output MemRead,
        output LoadEnable,
        output LoadValue,
        output OffsetEnable,
        output Offset,
        output Instr,
        output InstrValid,
        output Halted
    );

    modport slave (
        output CounterValue,
        output MemData,
        output MemReady,
        output Zero,
        output Stall,
        input  MemAddr,
        input  MemRead,
        input  LoadEnable,
        input  LoadValue,
        input  OffsetEnable,
        input  Offset,
        input  Instr,
        input  InstrValid,
        input  Halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer: steers an external program counter through
// step, relative-branch and absolute-load strobes while fetching 16-bit words.
module fetch_sequencer (
    input  logic              Clock,
    input  logic              Reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH        = 3'd0,
        ST_DECODE       = 3'd1,
        ST_FETCH_TARGET = 3'd2,
        ST_LOADPC       = 3'd3,
        ST_HALT         = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_BR   = 3'd1,
        OP_JMP  = 3'd2,
        OP_BZ   = 3'd3,
        OP_HALT = 3'd4,
        OP_DATA = 3'd5
    } op_t;

    function automatic op_t decode_op(input logic [3:0] opcode);
        op_t op;
        case (opcode)
            4'h0:    op = OP_NOP;
            4'h1:    op = OP_BR;
            4'h2:    op = OP_JMP;
            4'h3:    op = OP_BZ;
            4'hF:    op = OP_HALT;
            default: op = OP_DATA;
        endcase
        return op;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;
    logic [15:0] r_target;
    op_t         w_op;

    logic        w_mem_read;
    logic        w_load_enable;
    logic [15:0] w_load_value;
    logic        w_offset_enable;
    logic [8:0]  w_offset;
    logic        w_instr_valid;
    logic        w_halted;
    logic        w_ir_load;
    logic        w_target_load;

    assign w_op = decode_op(r_ir[15:12]);

    // Next-state and PC-control decode; Reset forces every strobe and value to zero.
    always_comb begin
        w_next_state    = r_state;
        w_mem_read      = 1'b0;
        w_load_enable   = 1'b0;
        w_load_value    = 16'h0000;
        w_offset_enable = 1'b0;
        w_offset        = 9'h000;
        w_instr_valid   = 1'b0;
        w_halted        = 1'b0;
        w_ir_load       = 1'b0;
        w_target_load   = 1'b0;

        if (Reset) begin
            w_next_state = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    w_mem_read    = 1'b1;
                    w_load_enable = 1'b1;
                    w_load_value  = bus.CounterValue;
                    if (bus.MemReady) begin
                        w_ir_load    = 1'b1;
                        w_next_state = ST_DECODE;
                    end else begin
                        w_next_state = ST_FETCH;
                    end
                end

                ST_DECODE: begin
                    if (bus.Stall) begin
                        w_load_enable = 1'b1;
                        w_load_value  = bus.CounterValue;
                        w_next_state  = ST_DECODE;
                    end else begin
                        case (w_op)
                            OP_NOP: begin
                                w_next_state = ST_FETCH;
                            end
                            OP_DATA: begin
                                w_instr_valid = 1'b1;
                                w_next_state  = ST_FETCH;
                            end
                            OP_BR: begin
                                w_offset_enable = 1'b1;
                                w_offset        = r_ir[8:0];
                                w_next_state    = ST_FETCH;
                            end
                            OP_BZ: begin
                                if (bus.Zero) begin
                                    w_offset_enable = 1'b1;
                                    w_offset        = r_ir[8:0];
                                end else begin
                                    w_offset_enable = 1'b0;
                                end
                                w_next_state = ST_FETCH;
                            end
                            // PC+1 moves onto the target word that follows the opcode.
                            OP_JMP: begin
                                w_next_state = ST_FETCH_TARGET;
                            end
                            OP_HALT: begin
                                w_load_enable = 1'b1;
                                w_load_value  = bus.CounterValue;
                                w_next_state  = ST_HALT;
                            end
                            default: begin
                                w_next_state = ST_FETCH;
                            end
                        endcase
                    end
                end

                ST_FETCH_TARGET: begin
                    w_mem_read    = 1'b1;
                    w_load_enable = 1'b1;
                    w_load_value  = bus.CounterValue;
                    if (bus.MemReady) begin
                        w_target_load = 1'b1;
                        w_next_state  = ST_LOADPC;
                    end else begin
                        w_next_state = ST_FETCH_TARGET;
                    end
                end

                ST_LOADPC: begin
                    w_load_enable = 1'b1;
                    w_load_value  = r_target;
                    w_next_state  = ST_FETCH;
                end

                ST_HALT: begin
                    w_load_enable = 1'b1;
                    w_load_value  = bus.CounterValue;
                    w_halted      = 1'b1;
                    w_next_state  = ST_HALT;
                end

                default: begin
                    w_next_state = ST_FETCH;
                end
            endcase
        end
    end

    // State, instruction register and jump target; a reset edge discards any MemReady.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= ST_FETCH;
            r_ir     <= 16'h0000;
            r_target <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (w_ir_load) begin
                r_ir <= bus.MemData;
            end
            if (w_target_load) begin
                r_target <= bus.MemData;
            end
        end
    end

    assign bus.MemAddr      = bus.CounterValue;
    assign bus.MemRead      = w_mem_read;
    assign bus.LoadEnable   = w_load_enable;
    assign bus.LoadValue    = w_load_value;
    assign bus.OffsetEnable = w_offset_enable;
    assign bus.Offset       = $signed(w_offset);
    assign bus.Instr        = r_ir;
    assign bus.InstrValid   = w_instr_valid;
    assign bus.Halted       = w_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural program counter and word
// memory surround the DUT; decode vectors come from a table, corner cases from sequences.
module tb_fetch_sequencer;

    logic Clock;
    logic Reset;
    logic [15:0] pc;
    logic [15:0] mem [0:65535];
    int n_pass;
    int n_total;
    int iv_count;
    bit ok;

    fetch_sequencer_if bus();

    fetch_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // External program counter following the LoadEnable/OffsetEnable contract.
    always_ff @(posedge Clock) begin
        if (Reset) pc <= 16'h0000;
        else if (bus.LoadEnable) pc <= bus.LoadValue;
        else if (bus.OffsetEnable) pc <= pc + {{7{bus.Offset[8]}}, bus.Offset};
        else pc <= pc + 16'h0001;
    end

    assign bus.CounterValue = pc;
    assign bus.MemData      = mem[pc];

    typedef struct packed {
        logic [15:0] word;
        logic        zero;
        logic        stall;
        logic        exp_le;
        logic [15:0] exp_lv;
        logic        exp_oe;
        logic [8:0]  exp_off;
        logic        exp_iv;
        logic [15:0] exp_next_addr;
        logic        exp_next_rd;
        logic        exp_next_halt;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #3;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.MemReady = 1'b1;
        bus.Stall = 1'b0;
        bus.Zero = 1'b0;
        step();
        Reset = 1'b0;
        #1;
    endtask

    task automatic wait_instr(input logic [15:0] w, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (bus.Instr === w) found = 1'b1;
            else step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        Reset = 1'b1;
        bus.MemReady = 1'b0;
        bus.Stall = 1'b0;
        bus.Zero = 1'b0;

        //            word     z     st    le    lv        oe    off     iv    naddr     nrd   nhalt
        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[1]  = '{16'h5ABC, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[2]  = '{16'h11FD, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h1FD, 1'b0, 16'hFFFD, 1'b1, 1'b0};
        vecs[3]  = '{16'h1005, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h005, 1'b0, 16'h0005, 1'b1, 1'b0};
        vecs[4]  = '{16'h3004, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[5]  = '{16'h3004, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h004, 1'b0, 16'h0004, 1'b1, 1'b0};
        vecs[6]  = '{16'h2000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[7]  = '{16'hF000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 9'h000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{16'h5ABC, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 9'h000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{16'hE123, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 9'h000, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[10] = '{16'h1100, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 9'h100, 1'b0, 16'hFF00, 1'b1, 1'b0};

        // Reset state, then an IR reset from DECODE with MemReady high in the reset cycle.
        clear_mem();
        mem[0] = 16'h5ABC;
        do_reset();
        bus.Stall = 1'b1;
        step();
        check("pre_reset_ir", {16'h0, bus.Instr}, 32'h5ABC);
        Reset = 1'b1;
        bus.MemReady = 1'b1;
        #1;
        check("rst_memread", {31'h0, bus.MemRead}, 32'h0);
        check("rst_loaden", {31'h0, bus.LoadEnable}, 32'h0);
        check("rst_loadval", {16'h0, bus.LoadValue}, 32'h0);
        check("rst_offen", {31'h0, bus.OffsetEnable}, 32'h0);
        check("rst_offset", {23'h0, bus.Offset}, 32'h0);
        check("rst_ivalid", {31'h0, bus.InstrValid}, 32'h0);
        check("rst_halted", {31'h0, bus.Halted}, 32'h0);
        step();
        Reset = 1'b0;
        bus.Stall = 1'b0;
        #1;
        check("rst_ir_cleared", {16'h0, bus.Instr}, 32'h0);
        check("rst_in_fetch", {31'h0, bus.MemRead}, 32'h1);
        check("rst_addr0", {16'h0, bus.MemAddr}, 32'h0);

        // Table of single-instruction decodes from address 0.
        for (int i = 0; i < NVEC; i++) begin
            clear_mem();
            mem[0] = vecs[i].word;
            do_reset();
            bus.Zero = vecs[i].zero;
            bus.Stall = vecs[i].stall;
            step();
            check($sformatf("v%0d_instr", i), {16'h0, bus.Instr}, {16'h0, vecs[i].word});
            check($sformatf("v%0d_loaden", i), {31'h0, bus.LoadEnable}, {31'h0, vecs[i].exp_le});
            check($sformatf("v%0d_loadval", i), {16'h0, bus.LoadValue}, {16'h0, vecs[i].exp_lv});
            check($sformatf("v%0d_offen", i), {31'h0, bus.OffsetEnable}, {31'h0, vecs[i].exp_oe});
            check($sformatf("v%0d_offset", i), {23'h0, bus.Offset}, {23'h0, vecs[i].exp_off});
            check($sformatf("v%0d_ivalid", i), {31'h0, bus.InstrValid}, {31'h0, vecs[i].exp_iv});
            step();
            check($sformatf("v%0d_next_addr", i), {16'h0, bus.MemAddr}, {16'h0, vecs[i].exp_next_addr});
            check($sformatf("v%0d_next_rd", i), {31'h0, bus.MemRead}, {31'h0, vecs[i].exp_next_rd});
            check($sformatf("v%0d_next_halt", i), {31'h0, bus.Halted}, {31'h0, vecs[i].exp_next_halt});
            bus.Stall = 1'b0;
            bus.Zero = 1'b0;
        end

        // All-NOP stream: each address held two cycles, no InstrValid.
        clear_mem();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            check($sformatf("nop_addr%0d", k), {16'h0, bus.MemAddr}, k / 2);
            check($sformatf("nop_iv%0d", k), {31'h0, bus.InstrValid}, 32'h0);
            step();
        end

        // BR -3 at address 5 lands on 2.
        clear_mem();
        mem[5] = 16'h11FD;
        do_reset();
        wait_instr(16'h11FD, 40, ok);
        check("br_seen", {31'h0, ok}, 32'h1);
        check("br_addr", {16'h0, bus.MemAddr}, 32'h5);
        check("br_offen", {31'h0, bus.OffsetEnable}, 32'h1);
        check("br_offset", {23'h0, bus.Offset}, 32'h1FD);
        step();
        check("br_target", {16'h0, bus.MemAddr}, 32'h2);

        // JMP at 0x10 with target word 0x1234; target read stalls one cycle.
        clear_mem();
        mem[16'h0010] = 16'h2000;
        mem[16'h0011] = 16'h1234;
        do_reset();
        wait_instr(16'h2000, 80, ok);
        check("jmp_seen", {31'h0, ok}, 32'h1);
        check("jmp_addr", {16'h0, bus.MemAddr}, 32'h10);
        step();
        bus.MemReady = 1'b0;
        #1;
        check("ft_addr", {16'h0, bus.MemAddr}, 32'h11);
        check("ft_rd", {31'h0, bus.MemRead}, 32'h1);
        check("ft_hold", {16'h0, bus.LoadValue}, 32'h11);
        step();
        check("ft_wait_addr", {16'h0, bus.MemAddr}, 32'h11);
        check("ft_wait_rd", {31'h0, bus.MemRead}, 32'h1);
        bus.MemReady = 1'b1;
        step();
        check("lp_loaden", {31'h0, bus.LoadEnable}, 32'h1);
        check("lp_loadval", {16'h0, bus.LoadValue}, 32'h1234);
        check("lp_rd", {31'h0, bus.MemRead}, 32'h0);
        step();
        check("jmp_dest", {16'h0, bus.MemAddr}, 32'h1234);
        check("jmp_dest_rd", {31'h0, bus.MemRead}, 32'h1);

        // BZ +4 at address 8 with Zero low then high.
        for (int z = 0; z < 2; z++) begin
            clear_mem();
            mem[8] = 16'h3004;
            do_reset();
            bus.Zero = (z == 1);
            wait_instr(16'h3004, 40, ok);
            check($sformatf("bz%0d_seen", z), {31'h0, ok}, 32'h1);
            check($sformatf("bz%0d_offen", z), {31'h0, bus.OffsetEnable}, z);
            step();
            check($sformatf("bz%0d_next", z), {16'h0, bus.MemAddr}, (z == 1) ? 32'd12 : 32'd9);
            bus.Zero = 1'b0;
        end

        // Slow memory plus two stall cycles on a data word.
        clear_mem();
        mem[0] = 16'h5ABC;
        do_reset();
        iv_count = 0;
        bus.MemReady = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("slow_addr%0d", k), {16'h0, bus.MemAddr}, 32'h0);
            check($sformatf("slow_hold%0d", k), {31'h0, bus.LoadEnable}, 32'h1);
            if (bus.InstrValid) iv_count++;
            step();
        end
        bus.MemReady = 1'b1;
        bus.Stall = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("stall_hold%0d", k), {31'h0, bus.LoadEnable}, 32'h1);
            check($sformatf("stall_addr%0d", k), {16'h0, bus.MemAddr}, 32'h0);
            check($sformatf("stall_iv%0d", k), {31'h0, bus.InstrValid}, 32'h0);
            if (bus.InstrValid) iv_count++;
            step();
        end
        bus.Stall = 1'b0;
        #1;
        check("data_iv", {31'h0, bus.InstrValid}, 32'h1);
        check("data_instr", {16'h0, bus.Instr}, 32'h5ABC);
        for (int k = 0; k < 8; k++) begin
            if (bus.InstrValid) iv_count++;
            step();
        end
        check("iv_pulses", iv_count, 32'd1);

        // HALT at address 3, then Reset out of HALT.
        clear_mem();
        mem[3] = 16'hF000;
        do_reset();
        wait_instr(16'hF000, 40, ok);
        check("halt_seen", {31'h0, ok}, 32'h1);
        step();
        for (int k = 0; k < 12; k++) begin
            check($sformatf("halt_flag%0d", k), {31'h0, bus.Halted}, 32'h1);
            check($sformatf("halt_addr%0d", k), {16'h0, bus.MemAddr}, 32'h3);
            check($sformatf("halt_rd%0d", k), {31'h0, bus.MemRead}, 32'h0);
            step();
        end
        Reset = 1'b1;
        #1;
        check("halt_rst_flag", {31'h0, bus.Halted}, 32'h0);
        step();
        Reset = 1'b0;
        #1;
        check("halt_exit_addr", {16'h0, bus.MemAddr}, 32'h0);
        check("halt_exit_rd", {31'h0, bus.MemRead}, 32'h1);
        check("halt_exit_flag", {31'h0, bus.Halted}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
